// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Purpose  : Writeback-side writer for the register bank write port. Merges
//            non-stallable single-cycle ALU results and handshaked load
//            results (buffered in a small FIFO) into one registered register
//            write per cycle. ALU results take priority. Queued loads whose
//            destination is overwritten by a younger ALU result are squashed.
//            Queued destinations are reported to hazard logic.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            alu_valid/alu_rd/alu_data - ALU result (cannot stall)
//            ld_valid/ld_ready/ld_rd/ld_data - load result handshake
//            writeReg/writedata/RegWrite - registered register-bank write
//            rs1_q/rs2_q -> rs1_pending/rs2_pending - pending-write queries
//            count                     - occupied FIFO slots (incl. squashed)
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [4:0]    ld_rd,
    input  logic [31:0]   ld_data,
    output logic [4:0]    writeReg,
    output logic [31:0]   writedata,
    output logic          RegWrite,
    input  logic [4:0]    rs1_q,
    input  logic [4:0]    rs2_q,
    output logic          rs1_pending,
    output logic          rs2_pending,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_alu_wr;
    logic w_push;
    logic w_pop;
    logic w_pop_wr;
    logic w_push_vld;

    // Writes to x0 are discarded, so they neither win arbitration nor squash.
    assign w_alu_wr   = alu_valid && (alu_rd != 5'd0);
    assign ld_ready   = (r_count != c_FULL);
    assign w_push     = ld_valid && ld_ready;
    // The head slot pops whenever the ALU does not own the port; a squashed
    // head simply retires without producing a write.
    assign w_pop      = !w_alu_wr && (r_count != '0);
    assign w_pop_wr   = w_pop && r_vld[r_rptr];
    // An ALU result in the same cycle is younger than the arriving load, so a
    // matching destination makes the load dead on arrival.
    assign w_push_vld = (ld_rd != 5'd0) && !(w_alu_wr && (ld_rd == alu_rd));
    assign count      = r_count;

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == rs1_q) && (rs1_q != 5'd0)) rs1_pending = 1'b1;
            if (r_vld[i] && (r_rd[i] == rs2_q) && (rs2_q != 5'd0)) rs2_pending = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            RegWrite  <= 1'b0;
            writeReg  <= 5'd0;
            writedata <= 32'd0;
        end else begin
            // Write-after-write: older queued loads to the same register die.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_wr && (r_rd[i] == alu_rd)) r_vld[i] <= 1'b0;
            end

            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + c_PTR_ONE;
            end

            // Push never targets the popped slot: that needs count==0 (no pop)
            // or count==DEPTH (no push).
            if (w_push) begin
                r_rd[r_wptr]   <= ld_rd;
                r_data[r_wptr] <= ld_data;
                r_vld[r_wptr]  <= w_push_vld;
                r_wptr         <= r_wptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            RegWrite <= w_alu_wr || w_pop_wr;
            if (w_alu_wr) begin
                writeReg  <= alu_rd;
                writedata <= alu_data;
            end else if (w_pop_wr) begin
                writeReg  <= r_rd[r_rptr];
                writedata <= r_data[r_rptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Purpose  : Self-checking bench for wb_write_queue. Directed scenarios plus a
//            randomized run compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  writeReg;
    logic [31:0] writedata;
    logic        RegWrite;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        rs1_pending;
    logic        rs2_pending;
    logic [AW:0] count;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .writeReg(writeReg), .writedata(writedata), .RegWrite(RegWrite),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .count(count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    bit          m_we = 1'b0;
    logic [4:0]  m_wr = 5'd0;
    logic [31:0] m_wd = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [AW:0] m_count();
        return (AW+1)'(mq.size());
    endfunction

    task automatic model_edge();
        bit   alu_wr;
        bit   acc;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
            return;
        end
        alu_wr = alu_valid && (alu_rd != 5'd0);
        acc    = ld_valid && (mq.size() != DEPTH);
        if (alu_wr) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].v = 1'b0;
            m_we = 1'b1; m_wr = alu_rd; m_wd = alu_data;
        end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_we = e.v;
            if (e.v) begin m_wr = e.rd; m_wd = e.data; end
        end else begin
            m_we = 1'b0;
        end
        if (acc) begin
            e.rd = ld_rd; e.data = ld_data;
            e.v  = (ld_rd != 5'd0) && !(alu_wr && ld_rd == alu_rd);
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; rs1_q = 5'd3; rs2_q = 5'd4;
        tick(); tick();
        reset = 1'b0; #1;
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_checks++; if (writeReg !== 5'd0) begin n_fail++; $display("FAIL reset_writereg: got %0d want 0", writeReg); end
        n_checks++; if (writedata !== 32'd0) begin n_fail++; $display("FAIL reset_writedata: got %h want 0", writedata); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b00) begin n_fail++; $display("FAIL reset_pending: got %b%b want 00", rs1_pending, rs2_pending); end
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        tick();
        alu_valid = 1'b0; #1;
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b want 1", RegWrite); end
        n_checks++; if (writeReg !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", writeReg); end
        n_checks++; if (writedata !== 32'hAA) begin n_fail++; $display("FAIL alu_data: got %h want 000000aa", writedata); end
        tick(); #1;
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %b want 0", RegWrite); end
        n_checks++; if (writeReg !== 5'd5 || writedata !== 32'hAA) begin n_fail++; $display("FAIL alu_hold: got %0d/%h want 5/000000aa", writeReg, writedata); end
    endtask

    task automatic test_load_stream();
        logic [4:0]  got_rd[$];
        logic [31:0] got_d[$];
        int          got_c[$];
        int          peak = 0;
        bit          rdy_ok = 1'b1;
        bit          ord_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin ld_valid = 1'b1; ld_rd = 5'(c + 1); ld_data = 32'h11 * (c + 1); end
            else ld_valid = 1'b0;
            #1;
            if (c < 4 && ld_ready !== 1'b1) rdy_ok = 1'b0;
            tick(); #1;
            if (int'(count) > peak) peak = int'(count);
            if (RegWrite === 1'b1) begin got_rd.push_back(writeReg); got_d.push_back(writedata); got_c.push_back(c); end
            n_checks++;
            if (RegWrite !== m_we || writeReg !== m_wr || writedata !== m_wd || count !== m_count()) begin
                n_fail++;
                $display("FAIL stream_model c=%0d: got we=%b rd=%0d d=%h cnt=%0d want we=%b rd=%0d d=%h cnt=%0d",
                         c, RegWrite, writeReg, writedata, count, m_we, m_wr, m_wd, m_count());
            end
        end
        if (got_rd.size() != 4) ord_ok = 1'b0;
        else foreach (got_rd[i])
            if (got_rd[i] != 5'(i + 1) || got_d[i] != 32'h11 * (i + 1) || got_c[i] != i + 1) ord_ok = 1'b0;
        n_checks++; if (!ord_ok) begin n_fail++; $display("FAIL stream_order: got %0d writes, want rd 1..4 on consecutive cycles", got_rd.size()); end
        n_checks++; if (peak < 1 || peak > 2) begin n_fail++; $display("FAIL stream_peak: got %0d want 1..2", peak); end
        n_checks++; if (!rdy_ok) begin n_fail++; $display("FAIL stream_ready: got ld_ready=0 want 1"); end
    endtask

    task automatic test_alu_backpressure();
        logic [4:0]  got_rd[$];
        logic [31:0] got_d[$];
        int          j = 0;
        int          peak = 0;
        bit          saw_stall = 1'b0;
        bit          acc;
        bit          ord_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            alu_valid = (c < 6); alu_rd = 5'd7; alu_data = 32'h700 + c;
            ld_valid = (j < 5); ld_rd = 5'(10 + j); ld_data = 32'h1000 + j;
            #1;
            if (j == 4 && ld_ready === 1'b0 && count === 3'd4) saw_stall = 1'b1;
            acc = ld_valid && (ld_ready === 1'b1);
            tick();
            if (acc) j++;
            #1;
            if (int'(count) > peak) peak = int'(count);
            if (RegWrite === 1'b1) begin got_rd.push_back(writeReg); got_d.push_back(writedata); end
            n_checks++;
            if (RegWrite !== m_we || writeReg !== m_wr || writedata !== m_wd || count !== m_count()) begin
                n_fail++;
                $display("FAIL bp_model c=%0d: got we=%b rd=%0d d=%h cnt=%0d want we=%b rd=%0d d=%h cnt=%0d",
                         c, RegWrite, writeReg, writedata, count, m_we, m_wr, m_wd, m_count());
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        if (got_rd.size() != 11) ord_ok = 1'b0;
        else foreach (got_rd[i]) begin
            if (i < 6 && (got_rd[i] != 5'd7 || got_d[i] != 32'h700 + i)) ord_ok = 1'b0;
            if (i >= 6 && (got_rd[i] != 5'(10 + i - 6) || got_d[i] != 32'h1000 + (i - 6))) ord_ok = 1'b0;
        end
        n_checks++; if (!ord_ok) begin n_fail++; $display("FAIL bp_order: got %0d writes, want 6 ALU then loads rd 10..14", got_rd.size()); end
        n_checks++; if (peak != 4) begin n_fail++; $display("FAIL bp_peak: got %0d want 4", peak); end
        n_checks++; if (!saw_stall) begin n_fail++; $display("FAIL bp_stall: got no ld_ready=0 at count 4, want stall on 5th load"); end
        n_checks++; if (j != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", j); end
    endtask

    task automatic test_waw_squash();
        rs1_q = 5'd9; rs2_q = 5'd12;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; alu_valid = 1'b0; #1;
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL waw_same_cycle_pending: got %b want 0", rs1_pending); end
        tick();
        ld_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55; #1;
        n_checks++; if (rs1_pending !== 1'b1) begin n_fail++; $display("FAIL waw_pending_set: got %b want 1", rs1_pending); end
        tick();
        alu_valid = 1'b0; #1;
        n_checks++; if (RegWrite !== 1'b1 || writeReg !== 5'd9 || writedata !== 32'h55) begin n_fail++; $display("FAIL waw_alu_write: got %b/%0d/%h want 1/9/00000055", RegWrite, writeReg, writedata); end
        n_checks++; if (rs1_pending !== 1'b0) begin n_fail++; $display("FAIL waw_pending_clr: got %b want 0", rs1_pending); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL waw_squashed_count: got %0d want 1", count); end
        tick(); #1;
        n_checks++; if (RegWrite !== 1'b0 || count !== 3'd0 || writedata !== 32'h55) begin n_fail++; $display("FAIL waw_silent_pop: got we=%b cnt=%0d d=%h want 0/0/00000055", RegWrite, count, writedata); end
        // Same-cycle squash: load and ALU to the same register together.
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h12; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h34;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0; #1;
        n_checks++; if (RegWrite !== 1'b1 || writedata !== 32'h34 || count !== 3'd1 || rs2_pending !== 1'b0) begin n_fail++; $display("FAIL waw_same_cycle: got we=%b d=%h cnt=%0d p2=%b want 1/00000034/1/0", RegWrite, writedata, count, rs2_pending); end
        tick(); #1;
        n_checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL waw_same_cycle_pop: got we=%b cnt=%0d want 0/0", RegWrite, count); end
    endtask

    task automatic test_x0_load();
        rs1_q = 5'd0; alu_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFF; #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", ld_ready); end
        tick();
        ld_valid = 1'b0; #1;
        n_checks++; if (count !== 3'd1 || RegWrite !== 1'b0 || rs1_pending !== 1'b0) begin n_fail++; $display("FAIL x0_queued: got cnt=%0d we=%b p1=%b want 1/0/0", count, RegWrite, rs1_pending); end
        tick(); #1;
        n_checks++; if (count !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_drain: got cnt=%0d we=%b want 0/0", count, RegWrite); end
    endtask

    task automatic test_reset_mid_drain();
        bit stale = 1'b0;
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2000 + c;
            ld_valid = 1'b1; ld_rd = 5'(21 + c); ld_data = 32'h2100 + c;
            tick();
        end
        alu_valid = 1'b0; ld_valid = 1'b0; rs1_q = 5'd21; rs2_q = 5'd23; #1;
        n_checks++; if (count !== 3'd3 || rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin n_fail++; $display("FAIL rst_fill: got cnt=%0d p=%b%b want 3/11", count, rs1_pending, rs2_pending); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        n_checks++; if (count !== 3'd0 || RegWrite !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_state: got cnt=%0d we=%b rdy=%b want 0/0/1", count, RegWrite, ld_ready); end
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b00) begin n_fail++; $display("FAIL rst_pending: got %b%b want 00", rs1_pending, rs2_pending); end
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            if (RegWrite !== 1'b0) stale = 1'b1;
        end
        n_checks++; if (stale) begin n_fail++; $display("FAIL rst_stale_write: got RegWrite=1 after reset want 0"); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 9) < 6);
            ld_rd     = 5'($urandom_range(0, 7));
            ld_data   = $urandom;
            rs1_q     = 5'($urandom_range(0, 7));
            rs2_q     = 5'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (ld_ready !== (mq.size() != DEPTH) || count !== m_count() ||
                rs1_pending !== m_pending(rs1_q) || rs2_pending !== m_pending(rs2_q)) begin
                n_fail++;
                $display("FAIL rand_comb c=%0d: got rdy=%b cnt=%0d p=%b%b want rdy=%b cnt=%0d p=%b%b",
                         c, ld_ready, count, rs1_pending, rs2_pending,
                         (mq.size() != DEPTH), m_count(), m_pending(rs1_q), m_pending(rs2_q));
            end
            tick(); #1;
            n_checks++;
            if (RegWrite !== m_we || writeReg !== m_wr || writedata !== m_wd) begin
                n_fail++;
                $display("FAIL rand_write c=%0d: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         c, RegWrite, writeReg, writedata, m_we, m_wr, m_wd);
            end
        end
        reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0; rs1_q = 5'd0; rs2_q = 5'd0;
        test_reset();
        test_alu_single();
        test_load_stream();
        test_alu_backpressure();
        test_waw_squash();
        test_x0_load();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
